alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc_if.sv | 25 ++
 rtl/alu_mc.sv | 209 ++++++++++++++++++++
 tb/tb_alu_mc.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// Request/response bundle for the multi-cycle ALU: operands and opcode in,
// registered result, flags and completion status out.
interface alu_mc_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       ALU_Sel;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Result;
    logic [3:0]       NZVC;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, ALU_Sel, A, B,
        input  Result, NZVC, busy, done, err
    );

    modport slave (
        input  start, ALU_Sel, A, B,
        output Result, NZVC, busy, done, err
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic, bit-serial shifts and an
// optional shift-add multiplier enabled by defining ALU_MC_MUL_EN.
module alu_mc #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     clock,
    input  logic     reset,
    alu_mc_if.slave  bus
);
    localparam int MSB = WIDTH - 1;
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_ADD = 4'h0, OP_INC = 4'h1, OP_SUB = 4'h2, OP_DEC = 4'h3,
                           OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7,
                           OP_ADC = 4'h8, OP_SBC = 4'h9, OP_SHL = 4'hA, OP_SHR = 4'hB,
                           OP_MUL = 4'hC;

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

    state_t           state;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       nzvc_q;
    logic             busy_q, done_q, err_q;

    logic [3:0]       op_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sh_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             v, c, legal, multi;

    logic [WIDTH-1:0] sh_nx, fin_res;
    logic             sh_out, fin_c;

    function automatic logic [3:0] flags(input logic [WIDTH-1:0] r, input logic fv,
                                         input logic fc);
        return {r[MSB], (r == '0), fv, fc};
    endfunction

    assign bus.Result = result_q;
    assign bus.NZVC   = nzvc_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;

    // Single-cycle datapath evaluated straight from the request inputs
    always_comb begin
        sum   = '0;
        res   = '0;
        v     = 1'b0;
        c     = 1'b0;
        legal = 1'b1;
        multi = 1'b0;
        case (bus.ALU_Sel)
            OP_ADD: begin
                sum = {1'b0, bus.A} + {1'b0, bus.B};
                res = sum[MSB:0];
                c   = sum[WIDTH];
                v   = (bus.A[MSB] == bus.B[MSB]) && (res[MSB] != bus.A[MSB]);
            end
            OP_INC: begin
                sum = {1'b0, bus.A} + {{WIDTH{1'b0}}, 1'b1};
                res = sum[MSB:0];
                c   = sum[WIDTH];
                v   = (bus.A == {1'b0, {(WIDTH-1){1'b1}}});
            end
            OP_SUB: begin
                sum = {1'b0, bus.A} - {1'b0, bus.B};
                res = sum[MSB:0];
                c   = sum[WIDTH];
                v   = (bus.A[MSB] != bus.B[MSB]) && (res[MSB] != bus.A[MSB]);
            end
            OP_DEC: begin
                sum = {1'b0, bus.A} - {{WIDTH{1'b0}}, 1'b1};
                res = sum[MSB:0];
                c   = sum[WIDTH];
                v   = (bus.A == {1'b1, {(WIDTH-1){1'b0}}});
            end
            OP_AND: res = bus.A & bus.B;
            OP_OR:  res = bus.A | bus.B;
            OP_XOR: res = bus.A ^ bus.B;
            OP_NOT: res = ~bus.A;
            OP_ADC: begin
                sum = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, nzvc_q[0]};
                res = sum[MSB:0];
                c   = sum[WIDTH];
                v   = (bus.A[MSB] == bus.B[MSB]) && (res[MSB] != bus.A[MSB]);
            end
            OP_SBC: begin
                sum = {1'b0, bus.A} - {1'b0, bus.B} - {{WIDTH{1'b0}}, nzvc_q[0]};
                res = sum[MSB:0];
                c   = sum[WIDTH];
                v   = (bus.A[MSB] != bus.B[MSB]) && (res[MSB] != bus.A[MSB]);
            end
            OP_SHL, OP_SHR: begin
                if (bus.B[SHW-1:0] == '0) res = bus.A;
                else                      multi = 1'b1;
            end
            OP_MUL: begin
`ifdef ALU_MC_MUL_EN
                multi = 1'b1;
`else
                legal = 1'b0;
`endif
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        if (op_q == OP_SHL) begin
            sh_nx  = {sh_q[MSB-1:0], 1'b0};
            sh_out = sh_q[MSB];
        end else begin
            sh_nx  = {1'b0, sh_q[MSB:1]};
            sh_out = sh_q[0];
        end
    end

`ifdef ALU_MC_MUL_EN
    logic [WIDTH-1:0] mcand_q, hi_q, lo_q, hi_nx, lo_nx;
    logic [WIDTH:0]   madd;

    // One shift-add step: add multiplicand on the multiplier LSB, then shift {carry,hi,lo} right
    always_comb begin
        madd  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        hi_nx = madd[WIDTH:1];
        lo_nx = {madd[0], lo_q[MSB:1]};
    end
`endif

    always_comb begin
        fin_res = sh_nx;
        fin_c   = sh_out;
`ifdef ALU_MC_MUL_EN
        if (op_q == OP_MUL) begin
            fin_res = lo_nx;
            fin_c   = |hi_nx;
        end
`endif
    end

    // Iteration state: loaded on accept, stepped once per EXEC cycle
    always_ff @(posedge clock) begin
        if (state == IDLE && bus.start) begin
            op_q  <= bus.ALU_Sel;
            sh_q  <= bus.A;
            cnt_q <= (bus.ALU_Sel == OP_MUL) ? CW'(WIDTH) : {1'b0, bus.B[SHW-1:0]};
`ifdef ALU_MC_MUL_EN
            mcand_q <= bus.A;
            hi_q    <= '0;
            lo_q    <= bus.B;
`endif
        end else if (state == EXEC) begin
            sh_q  <= sh_nx;
            cnt_q <= cnt_q - CW'(1);
`ifdef ALU_MC_MUL_EN
            hi_q <= hi_nx;
            lo_q <= lo_nx;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            result_q <= '0;
            nzvc_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (!legal) begin
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else if (multi) begin
                            busy_q <= 1'b1;
                            state  <= EXEC;
                        end else begin
                            result_q <= res;
                            nzvc_q   <= flags(res, v, c);
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_q == CW'(1)) begin
                        result_q <= fin_res;
                        nzvc_q   <= flags(fin_res, 1'b0, fin_c);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at WIDTH=8; MUL expectations follow ALU_MC_MUL_EN.
module tb_alu_mc;
    localparam logic [3:0] ADD = 4'h0, INC = 4'h1, SUB = 4'h2, DEC = 4'h3,
                           AND_ = 4'h4, OR_ = 4'h5, XOR_ = 4'h6, NOT_ = 4'h7,
                           ADC = 4'h8, SBC = 4'h9, SHL = 4'hA, SHR = 4'hB,
                           MUL = 4'hC, ILL = 4'hD;

    typedef struct {
        logic [3:0] sel;
        logic [7:0] a, b, res;
        logic [3:0] nzvc;
        logic       err;
        int         lat;
    } vec_t;

    logic clk, rst_n;
    int   n_cmp = 0, n_bad = 0;
    vec_t tbl[$];

    alu_mc_if #(.WIDTH(8)) bus ();
    alu_mc #(.WIDTH(8)) dut (.clock(clk), .reset(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] res, input logic [3:0] nzvc, input logic err,
                                input int lat);
        vec_t t;
        t.sel = sel; t.a = a; t.b = b; t.res = res; t.nzvc = nzvc; t.err = err; t.lat = lat;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    task automatic run_op(input vec_t t, input string nm);
        int e;
        bus.ALU_Sel = t.sel; bus.A = t.a; bus.B = t.b; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.A = ~t.a; bus.B = ~t.b; bus.ALU_Sel = ADD;
        @(negedge clk);
        chk({nm, ".busy"}, 32'(bus.busy), 32'(t.lat > 0));
        e = 0;
        while (!bus.done && e < 40) begin
            @(negedge clk);
            e++;
        end
        chk({nm, ".lat"}, 32'(e), 32'(t.lat));
        chk({nm, ".res"}, 32'(bus.Result), 32'(t.res));
        chk({nm, ".nzvc"}, 32'(bus.NZVC), 32'(t.nzvc));
        chk({nm, ".err"}, 32'(bus.err), 32'(t.err));
        chk({nm, ".busy_end"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk({nm, ".done_drop"}, 32'(bus.done), 32'd0);
        chk({nm, ".err_drop"}, 32'(bus.err), 32'd0);
    endtask

    initial begin
        vec_t mop;
        int   e;
        logic seen;

        tbl.push_back(mk(ADD,  8'h7F, 8'h01, 8'h80, 4'b1010, 1'b0, 0));
        tbl.push_back(mk(SUB,  8'h00, 8'h01, 8'hFF, 4'b1001, 1'b0, 0));
        tbl.push_back(mk(ADC,  8'h00, 8'h00, 8'h01, 4'b0000, 1'b0, 0));
        tbl.push_back(mk(SHL,  8'h81, 8'h01, 8'h02, 4'b0001, 1'b0, 1));
        tbl.push_back(mk(SHR,  8'h81, 8'h00, 8'h81, 4'b1000, 1'b0, 0));
        tbl.push_back(mk(INC,  8'h7F, 8'h00, 8'h80, 4'b1010, 1'b0, 0));
        tbl.push_back(mk(INC,  8'hFF, 8'h00, 8'h00, 4'b0101, 1'b0, 0));
        tbl.push_back(mk(SHL,  8'h55, 8'h00, 8'h55, 4'b0000, 1'b0, 0));
        tbl.push_back(mk(DEC,  8'h80, 8'h00, 8'h7F, 4'b0010, 1'b0, 0));
        tbl.push_back(mk(DEC,  8'h00, 8'h00, 8'hFF, 4'b1001, 1'b0, 0));
        tbl.push_back(mk(SBC,  8'h05, 8'h03, 8'h01, 4'b0000, 1'b0, 0));
        tbl.push_back(mk(SBC,  8'h00, 8'h00, 8'h00, 4'b0100, 1'b0, 0));
        tbl.push_back(mk(AND_, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0, 0));
        tbl.push_back(mk(OR_,  8'h00, 8'h00, 8'h00, 4'b0100, 1'b0, 0));
        tbl.push_back(mk(XOR_, 8'hAA, 8'hFF, 8'h55, 4'b0000, 1'b0, 0));
        tbl.push_back(mk(NOT_, 8'h0F, 8'h00, 8'hF0, 4'b1000, 1'b0, 0));
        tbl.push_back(mk(SUB,  8'h80, 8'h01, 8'h7F, 4'b0010, 1'b0, 0));
        tbl.push_back(mk(ADD,  8'hFF, 8'h01, 8'h00, 4'b0101, 1'b0, 0));
        tbl.push_back(mk(ILL,  8'h12, 8'h34, 8'h00, 4'b0101, 1'b1, 0));
        tbl.push_back(mk(ADC,  8'h01, 8'h01, 8'h03, 4'b0000, 1'b0, 0));
        tbl.push_back(mk(SHR,  8'h81, 8'h03, 8'h10, 4'b0000, 1'b0, 3));
        tbl.push_back(mk(SHL,  8'h81, 8'h07, 8'h80, 4'b1000, 1'b0, 7));
        tbl.push_back(mk(SHR,  8'hF0, 8'h05, 8'h07, 4'b0001, 1'b0, 5));
        tbl.push_back(mk(SHL,  8'h40, 8'hF9, 8'h80, 4'b1000, 1'b0, 1));
`ifdef ALU_MC_MUL_EN
        tbl.push_back(mk(MUL,  8'h10, 8'h20, 8'h00, 4'b0101, 1'b0, 8));
        tbl.push_back(mk(MUL,  8'h0F, 8'h0F, 8'hE1, 4'b1000, 1'b0, 8));
        mop = mk(MUL, 8'h10, 8'h20, 8'h00, 4'b0101, 1'b0, 8);
`else
        tbl.push_back(mk(MUL,  8'h10, 8'h20, 8'h80, 4'b1000, 1'b1, 0));
        tbl.push_back(mk(MUL,  8'h0F, 8'h0F, 8'h80, 4'b1000, 1'b1, 0));
        mop = mk(SHL, 8'h81, 8'h07, 8'h80, 4'b1000, 1'b0, 7);
`endif

        rst_n = 1'b0; bus.start = 1'b0; bus.ALU_Sel = 4'h0; bus.A = 8'h00; bus.B = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk("rst.res",  32'(bus.Result), 32'd0);
        chk("rst.nzvc", 32'(bus.NZVC), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.err",  32'(bus.err), 32'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) run_op(tbl[i], $sformatf("v%0d", i));

        // Requests arriving while busy and while in DONE must be dropped
        bus.ALU_Sel = mop.sel; bus.A = mop.a; bus.B = mop.b; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.ALU_Sel = ADD; bus.A = 8'h01; bus.B = 8'h01;
        @(negedge clk);
        chk("ign.busy", 32'(bus.busy), 32'd1);
        e = 0;
        while (!bus.done && e < 40) begin
            @(negedge clk);
            e++;
        end
        chk("ign.lat",  32'(e), 32'(mop.lat));
        chk("ign.res",  32'(bus.Result), 32'(mop.res));
        chk("ign.nzvc", 32'(bus.NZVC), 32'(mop.nzvc));
        @(negedge clk);
        bus.start = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            seen = seen | bus.done | bus.busy;
            @(negedge clk);
        end
        chk("ign.no_second_op", 32'(seen), 32'd0);
        chk("ign.res_hold", 32'(bus.Result), 32'(mop.res));

        // Asynchronous reset in the middle of a multi-cycle operation
        bus.ALU_Sel = mop.sel; bus.A = mop.a; bus.B = mop.b; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("mid.busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid.busy", 32'(bus.busy), 32'd0);
        chk("mid.res",  32'(bus.Result), 32'd0);
        chk("mid.nzvc", 32'(bus.NZVC), 32'd0);
        chk("mid.done", 32'(bus.done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen = seen | bus.done | bus.busy;
        end
        chk("mid.no_done", 32'(seen), 32'd0);
        run_op(mk(ADD, 8'h01, 8'h02, 8'h03, 4'b0000, 1'b0, 0), "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
